// File: rtl/out_pacer.sv
// out_pacer: paces bytes written to the output port so that each byte stays
// on the display register for at least HOLD_CYCLES clock edges.
// Bytes are queued in a DEPTH-entry FIFO and replayed with a one-cycle load
// strobe (oi_out).
// Optional build macro: OUT_PACER_OVERWRITE_EN. When it is defined, a write
// to a full FIFO replaces the oldest entry. When it is undefined, the new
// byte is dropped. In both cases the sticky overflow flag is set.
//
// state | meaning
// IDLE  | nothing on hold, waiting for queued data
// HOLD  | a byte was just loaded, minimum display time still running
module out_pacer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 1000000,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          oi_in,
    input  logic [7:0]    bus_in,
    output logic          oi_out,
    output logic [7:0]    bus_out,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          holding,
    output logic          overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HW-1:0]   r_hold_cnt;
    logic [HW-1:0]   w_hold_cnt_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_bus_out;
    logic            r_oi_out;
    logic            r_overflow;

    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_lost;
    logic            w_replace;
    logic            w_mem_we;
    logic            w_rd_adv;

    assign w_full = (r_count == DEPTH_C);
    assign w_push = oi_in && (!w_full || w_pop);
    // a write that finds the FIFO full with no pop on the same edge
    assign w_lost = oi_in && w_full && !w_pop;

`ifdef OUT_PACER_OVERWRITE_EN
    assign w_replace = w_lost;
`else
    assign w_replace = 1'b0;
`endif

    assign w_mem_we = w_push || w_replace;
    assign w_rd_adv = w_pop || w_replace;

    // FSM state and hold counter register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // next state, hold counter and pop decision
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop          = 1'b1;
                    w_hold_cnt_nxt = HOLD_LOAD;
                    w_state_nxt    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt != '0) begin
                    w_hold_cnt_nxt = r_hold_cnt - 1'b1;
                end else if (r_count != '0) begin
                    w_pop          = 1'b1;
                    w_hold_cnt_nxt = HOLD_LOAD;
                end else begin
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= bus_in;
        end
    end

    // pointers, occupancy, display load and sticky overflow
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_bus_out  <= 8'h00;
            r_oi_out   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_mem_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            r_oi_out <= w_pop;
            if (w_pop) begin
                r_bus_out <= r_mem[r_rd_ptr];
            end
            if (w_lost) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign oi_out   = r_oi_out;
    assign bus_out  = r_bus_out;
    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign full     = w_full;
    assign holding  = (r_state == ST_HOLD);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_out_pacer.sv
// Testbench for out_pacer: directed scenarios plus a randomized run, all
// compared against a queue-based reference model. The model works from
// pop timestamps rather than from a state machine.
module tb_out_pacer;

    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int VW    = 13 + CW;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          oi_in = 1'b0;
    logic [7:0]    bus_in = 8'h00;
    logic          oi_out;
    logic [7:0]    bus_out;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          holding;
    logic          overflow;

    out_pacer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .clr(clr), .oi_in(oi_in), .bus_in(bus_in),
        .oi_out(oi_out), .bus_out(bus_out), .count(count), .empty(empty),
        .full(full), .holding(holding), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0] q[$];
    int         edge_no  = 0;
    int         last_pop = 0;
    bit         m_hold   = 0;
    bit         m_oi     = 0;
    logic [7:0] m_bus    = 8'h00;
    bit         m_ovf    = 0;

    wire [VW-1:0] dut_vec = {oi_out, bus_out, count, empty, full, holding, overflow};

    function automatic logic [VW-1:0] exp_vec();
        return {m_oi, m_bus, CW'(q.size()), 1'(q.size() == 0),
                1'(q.size() == DEPTH), m_hold, m_ovf};
    endfunction

    task automatic model_reset();
        q.delete();
        m_hold = 0; m_oi = 0; m_bus = 8'h00; m_ovf = 0; last_pop = 0;
    endtask

    // one rising edge as seen by the model
    task automatic model_edge(input bit oi, input logic [7:0] d);
        int  pre;
        bit  pop;
        pre = q.size();
        pop = (pre > 0) && (!m_hold || (edge_no - last_pop >= HOLD));
        m_oi = pop;
        if (pop) begin
            m_bus    = q.pop_front();
            last_pop = edge_no;
            m_hold   = 1;
        end else if (m_hold && (edge_no - last_pop >= HOLD)) begin
            m_hold = 0;
        end
        if (oi) begin
            if (pre < DEPTH || pop) begin
                q.push_back(d);
            end else begin
                m_ovf = 1;
`ifdef OUT_PACER_OVERWRITE_EN
                void'(q.pop_front());
                q.push_back(d);
`endif
            end
        end
        edge_no++;
    endtask

    task automatic tick(input bit oi, input logic [7:0] d);
        oi_in  = oi;
        bus_in = d;
        @(posedge clk);
        model_edge(oi, d);
        #1;
        oi_in  = 1'b0;
        bus_in = 8'h00;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        model_reset();
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec, exp_vec());
        end
        tick(1, 8'hA1); tick(1, 8'hB2); tick(1, 8'hC3); tick(0, 8'h00);
        n_tests++;
        if (count !== CW'(2) || holding !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_setup: got count=%0d holding=%b expected count=2 holding=1", count, holding);
        end
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if ({oi_out, bus_out, count, empty, holding, overflow} !== {1'b0, 8'h00, CW'(0), 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got oi=%b bus=%h count=%0d empty=%b holding=%b ovf=%b expected 0 00 0 1 0 0",
                     oi_out, bus_out, count, empty, holding, overflow);
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_single();
        int pulse_at = -1;
        int idle_at  = -1;
        do_reset();
        for (int k = 0; k < 3 * HOLD; k++) begin
            tick(k == 0, (k == 0) ? 8'h2A : 8'h00);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_vec edge %0d: got %h expected %h", k, dut_vec, exp_vec());
            end
            if (oi_out && pulse_at < 0) pulse_at = k;
            if (pulse_at >= 0 && !holding && idle_at < 0) idle_at = k;
        end
        n_tests++;
        if (pulse_at != 1 || idle_at != HOLD + 1) begin
            n_fail++;
            $display("FAIL single_timing: got pulse=%0d idle=%0d expected pulse=1 idle=%0d", pulse_at, idle_at, HOLD + 1);
        end
    endtask

    task automatic test_burst();
        logic [7:0] data [3];
        int         at   [3];
        int         n = 0;
        data[0] = 8'h11; data[1] = 8'h22; data[2] = 8'h33;
        do_reset();
        for (int k = 0; k < 4 * HOLD + 4; k++) begin
            tick(k < 3, (k < 3) ? data[k] : 8'h00);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL burst_vec edge %0d: got %h expected %h", k, dut_vec, exp_vec());
            end
            if (oi_out) begin
                n_tests++;
                if (n >= 3 || at_mismatch(k, n, bus_out, data[n < 3 ? n : 0])) begin
                    n_fail++;
                    $display("FAIL burst_pulse %0d: got edge %0d byte %h expected edge %0d byte %h",
                             n, k, bus_out, 1 + n * HOLD, data[n < 3 ? n : 0]);
                end
                if (n < 3) at[n] = k;
                n++;
            end
        end
        n_tests++;
        if (n != 3 || empty !== 1'b1 || holding !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_end: got pulses=%0d empty=%b holding=%b expected 3 1 0", n, empty, holding);
        end
    endtask

    function automatic bit at_mismatch(input int k, input int n, input logic [7:0] got, input logic [7:0] want);
        return (k != 1 + n * HOLD) || (got !== want);
    endfunction

    // drain until the model is idle and empty, collecting popped bytes
    task automatic drain(output logic [7:0] popped[$], input string tag);
        int guard = 0;
        popped.delete();
        while ((m_hold || q.size() != 0) && guard < 20 * HOLD) begin
            tick(0, 8'h00);
            guard++;
            if (oi_out) popped.push_back(bus_out);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s_drain_vec: got %h expected %h", tag, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (guard >= 20 * HOLD) begin
            n_fail++;
            $display("FAIL %s_drain_timeout: got still busy expected idle", tag);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] popped[$];
        logic [7:0] want[$];
`ifdef OUT_PACER_OVERWRITE_EN
        want = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06};
`else
        want = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`endif
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick(1, 8'(k + 1));
            if (k == 4) begin
                n_tests++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_full: got full=%b ovf=%b expected 1 0", full, overflow);
                end
            end
        end
        n_tests++;
        if (overflow !== 1'b1 || count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL ovf_flag: got ovf=%b count=%0d expected 1 %0d", overflow, count, DEPTH);
        end
        drain(popped, "ovf");
        popped.push_front(8'h01);
        n_tests++;
        if (popped != want) begin
            n_fail++;
            $display("FAIL ovf_order: got %p expected %p", popped, want);
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] popped[$];
        logic [7:0] want[$];
        want = '{8'h20, 8'h30, 8'h40, 8'h50, 8'hAA};
        do_reset();
        for (int k = 0; k <= HOLD + 1; k++) begin
            if (k < 5)             tick(1, 8'((k + 1) * 16));
            else if (k == HOLD + 1) tick(1, 8'hAA);
            else                   tick(0, 8'h00);
            if (k == HOLD) begin
                n_tests++;
                if (count !== CW'(DEPTH)) begin
                    n_fail++;
                    $display("FAIL b2b_prefull: got count=%0d expected %0d", count, DEPTH);
                end
            end
        end
        n_tests++;
        if (count !== CW'(DEPTH) || oi_out !== 1'b1 || bus_out !== 8'h20 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_push_pop: got count=%0d oi=%b bus=%h ovf=%b expected %0d 1 20 0",
                     count, oi_out, bus_out, overflow, DEPTH);
        end
        drain(popped, "b2b");
        popped.push_front(8'h20);
        n_tests++;
        if (popped != want) begin
            n_fail++;
            $display("FAIL b2b_order: got %p expected %p", popped, want);
        end
    endtask

    task automatic test_random();
        int rate;
        bit oi;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 250 == 0) rate = $urandom_range(1, 12);
            oi = ($urandom_range(0, rate) == 0);
            tick(oi, 8'($urandom));
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_vec edge %0d: got %h expected %h", k, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/out_pacer.md
# out_pacer

Output pacing buffer between the control unit and the output display stage. Captures every byte the program writes to the output port (bus value with the OUT strobe), queues it in a small FIFO, and replays each byte to the display register with a one-cycle load strobe. It then holds that byte for a fixed minimum number of cycles, so fast back-to-back OUT instructions stay readable on the multiplexed seven-segment display.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- HOLD_CYCLES, 1000000: minimum clk edges between successive display loads; ≥2.
- CW, $clog2(DEPTH+1): occupancy width (derived).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- oi_in  in  1  OUT strobe from control; sampled on rising clk.
- bus_in  in  8  bus value written when oi_in=1.
- oi_out  out  1  one-cycle load strobe to the display register.
- bus_out  out  8  byte presented to the display register; valid while oi_out=1, stable until the next load.
- count  out  CW  FIFO occupancy, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- holding  out  1  FSM in HOLD.
- overflow  out  1  sticky; set when a write is lost; cleared only by clr.

## Operation
- Reset (clr=1, immediate): FIFO pointers=0, count=0, empty=1, full=0, oi_out=0, bus_out=8'h00, holding=0, overflow=0, state IDLE, hold counter=0. Queued data is discarded; a reset mid-HOLD aborts the hold.
- Push: at an edge with oi_in=1, bus_in is written at the write pointer if the FIFO is not full, or if a pop occurs on the same edge.
- Full write with no pop: the new byte is dropped, overflow←1, and the FIFO is unchanged. See Configuration for the alternative.
- FSM states:
  - IDLE: if count≠0, pop the head: bus_out←head, oi_out←1, hold counter←HOLD_CYCLES-1, state→HOLD. Otherwise stay in IDLE with oi_out=0.
  - HOLD: oi_out←0 and the counter decrements each edge. When the counter is 0:
    - if count≠0, pop immediately (same actions as IDLE; stay in HOLD);
    - else state→IDLE.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, the push is accepted.
- Push into an empty FIFO does not bypass: the byte is popped at the following edge.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never goes below 0.

## Timing
- Write at edge E0 into an empty FIFO in IDLE:
  - count=1 after E0;
  - pop at E1: oi_out=1 and bus_out=data during the cycle E1→E2;
  - display latches at E2, when oi_out returns to 0.
- Successive pops are exactly HOLD_CYCLES edges apart when data is waiting.
- holding=1 from the first pop until the edge at which the FSM returns to IDLE.
- All outputs are registered; there is no combinational path from oi_in or bus_in to any output.

## Configuration
- OUT_PACER_OVERWRITE_EN
  - Defined: a write to a full FIFO without a concurrent pop overwrites the oldest entry. Both pointers advance, count stays DEPTH, overflow←1, and the newest DEPTH bytes are kept.
  - Undefined: the newest byte is dropped (default behaviour above).

## Test plan
- Reset: assert clr mid-HOLD with count=2 -> outputs immediately become oi_out=0, bus_out=00, count=0, empty=1, holding=0, overflow=0.
- Single write (HOLD_CYCLES=4): oi_in=1 with bus_in=8'h2A at E0 -> oi_out=1 with bus_out=2A during E1→E2 only; holding=1 from E1; back to IDLE at E5.
- Burst (HOLD_CYCLES=4, DEPTH=4): write 11,22,33 on consecutive edges -> oi_out pulses at E1, E5, E9 with bus_out 11, 22, 33; then IDLE and empty=1.
- Overflow, macro undefined: with DEPTH=4 and HOLD_CYCLES=100, write 01..06 on consecutive edges. 01 is popped at E1, so 02..05 fill the FIFO and full=1 after E4. The 06 write at E5 is dropped and overflow=1. Subsequent pops give 02, 03, 04, 05.
- Overflow, OUT_PACER_OVERWRITE_EN defined: same stimulus -> 02 is overwritten; pops give 03, 04, 05, 06; overflow=1.
- Push with pop when full: at the HOLD-expiry edge with count=4, apply oi_in=1 and bus_in=AA -> count stays 4 and AA becomes the tail; popped last.
